// File: rtl/sorter_sequencer.sv
// Operand buffer plus sequential scanner that finds the two largest values and their slots.
// Results are presented with a one-cycle load strobe.
module sorter_sequencer #(
  parameter int N_NUM = 5,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         enter,
  input  logic         st,
  input  logic         clear,
  output logic [2:0]   count,
  output logic         full,
  output logic         busy,
  output logic [W-1:0] largest,
  output logic [W-1:0] second,
  output logic [2:0]   idx1,
  output logic [2:0]   idx2,
  output logic         load,
  output logic         done
);

  localparam logic [2:0] NUM  = 3'(N_NUM);
  localparam logic [2:0] LAST = 3'(N_NUM - 1);

  typedef enum logic [1:0] {ENTRY, SCAN, LOAD} state_t;
  state_t state, state_nxt;

  logic [N_NUM-1:0][W-1:0] mem;
  logic [2:0]              scan_i;
  logic [W-1:0]            run_max, run_sec, nxt_max, nxt_sec, v;
  logic [2:0]              run_i1, run_i2, nxt_i1, nxt_i2;
  logic                    sec_vld, nxt_vld;
  logic                    start;

  assign full  = (count == NUM);
  assign busy  = (state != ENTRY);
  assign load  = (state == LOAD);
  // st is judged on the pre-enter count, and wins over a same-cycle enter
  assign start = (state == ENTRY) && !clear && st && full;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ENTRY;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ENTRY: if (start) state_nxt = SCAN;
      SCAN:  if (clear) state_nxt = ENTRY;
             else if (scan_i == LAST) state_nxt = LOAD;
      LOAD:  state_nxt = ENTRY;
      default: state_nxt = ENTRY;
    endcase
  end

  // One compare step; strict > keeps the lowest index on ties
  always_comb begin
    v       = mem[scan_i];
    nxt_max = run_max;
    nxt_i1  = run_i1;
    nxt_sec = run_sec;
    nxt_i2  = run_i2;
    nxt_vld = sec_vld;
    if (v > run_max) begin
      nxt_sec = run_max;
      nxt_i2  = run_i1;
      nxt_max = v;
      nxt_i1  = scan_i;
      nxt_vld = 1'b1;
    end else if (!sec_vld || v > run_sec) begin
      nxt_sec = v;
      nxt_i2  = scan_i;
      nxt_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      count   <= '0;
      scan_i  <= '0;
      run_max <= '0;
      run_sec <= '0;
      run_i1  <= '0;
      run_i2  <= '0;
      sec_vld <= 1'b0;
      largest <= '0;
      second  <= '0;
      idx1    <= '0;
      idx2    <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (clear) begin
            count <= '0;
            done  <= 1'b0;
          end else if (start) begin
            run_max <= mem[0];
            run_i1  <= '0;
            run_sec <= '0;
            run_i2  <= '0;
            sec_vld <= 1'b0;
            scan_i  <= 3'd1;
            done    <= 1'b0;
          end else if (enter && !full) begin
            mem[count] <= din;
            count      <= count + 3'd1;
            done       <= 1'b0;
          end
        end
        SCAN: begin
          if (clear) begin
            count <= '0;
            done  <= 1'b0;
          end else begin
            run_max <= nxt_max;
            run_i1  <= nxt_i1;
            run_sec <= nxt_sec;
            run_i2  <= nxt_i2;
            sec_vld <= nxt_vld;
            scan_i  <= scan_i + 3'd1;
            if (scan_i == LAST) begin
              largest <= nxt_max;
              idx1    <= nxt_i1;
              second  <= nxt_sec;
              idx2    <= nxt_i2;
              done    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_sequencer.sv
// Randomized and directed checks of sorter_sequencer against a max/second-max reference model.
module tb_sorter_sequencer;
  localparam int N = 5;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         enter = 1'b0, st = 1'b0, clear = 1'b0;
  logic [2:0]   count, idx1, idx2;
  logic         full, busy, load, done;
  logic [W-1:0] largest, second;

  sorter_sequencer #(.N_NUM(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .enter(enter), .st(st), .clear(clear),
    .count(count), .full(full), .busy(busy), .largest(largest), .second(second),
    .idx1(idx1), .idx2(idx2), .load(load), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [W-1:0] m [0:N-1];
  int mcnt = 0;
  // last loaded results, expected to hold between loads
  logic [W-1:0] hl = '0, hs = '0;
  int hi1 = 0, hi2 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // largest = first index holding the max; second = best of the rest, lowest index on ties
  task automatic compute_ref(output logic [W-1:0] l, output logic [W-1:0] s,
                             output int i1, output int i2);
    i1 = 0;
    for (int i = 1; i < N; i++) if (m[i] > m[i1]) i1 = i;
    i2 = -1;
    for (int i = 0; i < N; i++)
      if (i != i1 && (i2 < 0 || m[i] > m[i2])) i2 = i;
    l = m[i1];
    s = m[i2];
  endtask

  task automatic do_enter(input logic [W-1:0] val);
    din = val; enter = 1'b1;
    tick();
    enter = 1'b0;
    if (mcnt < N) begin m[mcnt] = val; mcnt++; end
    n_cmp++;
    if (int'(count) !== mcnt || full !== (mcnt == N)) begin
      n_err++;
      $display("FAIL enter_count: count=%0d full=%0b, required count=%0d full=%0b",
               count, full, mcnt, mcnt == N);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mcnt = 0;
    n_cmp++;
    if (count !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear: count=%0d done=%0b busy=%0b, required 0 0 0", count, done, busy);
    end
  endtask

  task automatic sort_check(input string name, input bit with_enter, input logic [W-1:0] ev);
    logic [W-1:0] l, s;
    int i1, i2;
    st = 1'b1;
    if (with_enter) begin enter = 1'b1; din = ev; end
    compute_ref(l, s, i1, i2);
    for (int cyc = 1; cyc <= N + 1; cyc++) begin
      tick();
      st = 1'b0; enter = 1'b0;
      n_cmp++;
      if (busy !== (cyc <= N) || load !== (cyc == N)) begin
        n_err++;
        $display("FAIL %s_timing cyc%0d: busy=%0b load=%0b, required busy=%0b load=%0b",
                 name, cyc, busy, load, cyc <= N, cyc == N);
      end
      if (cyc == 1) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_err++;
          $display("FAIL %s_done_clr: done=%0b, required 0", name, done);
        end
      end
      if (cyc == N) begin
        n_cmp++;
        if (largest !== l || second !== s || int'(idx1) !== i1 || int'(idx2) !== i2 || done !== 1'b1) begin
          n_err++;
          $display("FAIL %s_result: L=%0d S=%0d i1=%0d i2=%0d done=%0b, required L=%0d S=%0d i1=%0d i2=%0d done=1",
                   name, largest, second, idx1, idx2, done, l, s, i1, i2);
        end
      end
    end
    hl = l; hs = s; hi1 = i1; hi2 = i2;
    n_cmp++;
    if (int'(count) !== mcnt || done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_after: count=%0d done=%0b, required count=%0d done=1", name, count, done, mcnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({count, full, busy, largest, second, idx1, idx2, load, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: count=%0d full=%0b busy=%0b L=%0d S=%0d i1=%0d i2=%0d load=%0b done=%0b, required all 0",
               count, full, busy, largest, second, idx1, idx2, load, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mcnt = 0;
  endtask

  task automatic test_basic();
    do_enter(4'd3); do_enter(4'd9); do_enter(4'd1); do_enter(4'd12); do_enter(4'd7);
    sort_check("basic", 1'b0, '0);
    n_cmp++;
    if (largest !== 4'd12 || idx1 !== 3'd3 || second !== 4'd9 || idx2 !== 3'd1) begin
      n_err++;
      $display("FAIL basic_const: L=%0d i1=%0d S=%0d i2=%0d, required 12 3 9 1", largest, idx1, second, idx2);
    end
  endtask

  task automatic test_directed();
    do_clear();
    do_enter(4'd5); do_enter(4'd5); do_enter(4'd2); do_enter(4'd0); do_enter(4'd1);
    sort_check("dup_max", 1'b0, '0);
    do_clear();
    for (int i = 0; i < N; i++) do_enter(4'd0);
    sort_check("zeros", 1'b0, '0);
    do_clear();
    do_enter(4'd15); do_enter(4'd1); do_enter(4'd15); do_enter(4'd15); do_enter(4'd2);
    sort_check("fifteens", 1'b0, '0);
    n_cmp++;
    if (idx1 !== 3'd0 || idx2 !== 3'd2) begin
      n_err++;
      $display("FAIL fifteens_idx: i1=%0d i2=%0d, required 0 2", idx1, idx2);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      do_clear();
      for (int i = 0; i < N; i++)
        do_enter((t % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 3)));
      sort_check("random", 1'b0, '0);
    end
  endtask

  task automatic test_not_full();
    do_clear();
    for (int i = 0; i < N - 1; i++) do_enter(W'(i + 1));
    st = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      st = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || load !== 1'b0 || count !== 3'(N - 1)) begin
        n_err++;
        $display("FAIL st_not_full: busy=%0b load=%0b count=%0d, required 0 0 %0d", busy, load, count, N - 1);
      end
    end
  endtask

  task automatic test_overflow();
    do_enter(4'd8);
    do_enter(4'd15);
    sort_check("overflow", 1'b0, '0);
    n_cmp++;
    if (largest !== 4'd8 || idx1 !== 3'd4) begin
      n_err++;
      $display("FAIL overflow_buf4: L=%0d i1=%0d, required 8 4", largest, idx1);
    end
  endtask

  task automatic test_st_enter();
    do_clear();
    do_enter(4'd2); do_enter(4'd6); do_enter(4'd4); do_enter(4'd1); do_enter(4'd3);
    sort_check("st_enter", 1'b1, 4'd14);
  endtask

  task automatic test_clear_abort();
    do_clear();
    do_enter(4'd15); do_enter(4'd14); do_enter(4'd0); do_enter(4'd0); do_enter(4'd0);
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mcnt = 0;
    for (int c = 0; c < N + 2; c++) begin
      n_cmp++;
      if (load !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || largest !== hl || second !== hs ||
          int'(idx1) !== hi1 || int'(idx2) !== hi2) begin
        n_err++;
        $display("FAIL clear_abort: load=%0b busy=%0b count=%0d L=%0d S=%0d i1=%0d i2=%0d, required 0 0 0 %0d %0d %0d %0d",
                 load, busy, count, largest, second, idx1, idx2, hl, hs, hi1, hi2);
      end
      tick();
    end
  endtask

  task automatic test_resort();
    do_clear();
    do_enter(4'd7); do_enter(4'd11); do_enter(4'd11); do_enter(4'd3); do_enter(4'd10);
    sort_check("resort1", 1'b0, '0);
    tick();
    sort_check("resort2", 1'b0, '0);
  endtask

  task automatic test_async_reset();
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, full, busy, largest, second, idx1, idx2, load, done} !== '0) begin
      n_err++;
      $display("FAIL async_reset: count=%0d busy=%0b L=%0d S=%0d i1=%0d i2=%0d load=%0b done=%0b, required all 0",
               count, busy, largest, second, idx1, idx2, load, done);
    end
    mcnt = 0;
    for (int c = 0; c < N + 1; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      n_cmp++;
      if (load !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_load: load=%0b busy=%0b, required 0 0", load, busy);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_not_full();
    test_overflow();
    test_st_enter();
    test_clear_abort();
    test_resort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sorter_sequencer.md
Name: sorter_sequencer

Overview:
- Front-end controller for the two-largest sorter datapath.
- Collects five 4-bit operands entered one at a time from switches into an internal buffer.
- On start, scans the buffer sequentially, one operand per cycle, to find the largest and second-largest values and their slot indices.
- Presents the results with a single-cycle load strobe to the downstream register file.

Parameters:
- N_NUM, 5, number of operands per sort (2..7).
- W, 4, operand width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  operand value from switches.
- enter  input  1  one-cycle pulse; write din into the next free slot.
- st  input  1  one-cycle pulse; start a scan.
- clear  input  1  one-cycle pulse; empty the buffer, or abort a scan.
- count  output  3  number of slots filled (0..N_NUM).
- full  output  1  count == N_NUM.
- busy  output  1  high while in SCAN or LOAD.
- largest  output  W  largest operand.
- second  output  W  second-largest operand.
- idx1  output  3  slot index (0-based) of largest.
- idx2  output  3  slot index (0-based) of second.
- load  output  1  one-cycle strobe; largest/second/idx1/idx2 are valid this cycle.
- done  output  1  sticky; set with load, cleared by clear, enter or st acceptance.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state ENTRY, count 0, buffer contents don't-care. Reset mid-scan discards the scan and raises no load.
- States: ENTRY, SCAN, LOAD.

ENTRY:
- clear: count<=0, done<=0. clear has priority over enter and st in the same cycle.
- enter with count<N_NUM: buf[count]<=din, count<=count+1, done<=0.
- enter with count==N_NUM: ignored; no overwrite, no wrap.
- st with full==1: latch buf[0] as running max (idx 0), second invalid, i<=1, go to SCAN, busy<=1, done<=0.
- st with full==0: ignored.
- st and enter in the same cycle: st is judged on the pre-enter count. If it is accepted, enter is ignored.

SCAN (N_NUM-1 cycles, i = 1..N_NUM-1), for v = buf[i]:
- If v > max: second<=max, idx2<=idx1, max<=v, idx1<=i.
- Else if second invalid or v > second: second<=v, idx2<=i, mark valid.
- Else: no change.
- Comparisons are unsigned W-bit and strict. The result is largest = maximum value at the lowest index. Second = maximum of the remaining slots at the lowest index. Duplicates of the maximum make second == largest.
- enter and st are ignored during SCAN.
- clear aborts the scan: return to ENTRY, count<=0, no load, result outputs keep their prior values.
- After processing i == N_NUM-1, go to LOAD.

LOAD (1 cycle):
- largest, second, idx1 and idx2 update on entry to this cycle.
- load=1 for exactly one cycle; done<=1.
- Next state is ENTRY with the buffer and count retained, so a new st re-sorts the same data.
- Inputs arriving during LOAD are ignored.

Latency and output hold:
- st accepted at edge k gives load high in cycle k+N_NUM (k+5 at default). busy is high from k+1 through the load cycle.
- Result outputs hold their value between loads. They change only in the load cycle.

Test Plan:
- Reset then enter 3,9,1,12,7, then st. Required: count steps 1..5 and full=1. Exactly 5 cycles after st, load pulses once with largest=12, idx1=3, second=9, idx2=1, done=1.
- Enter 5,5,2,0,1 and start. Required: largest=5, idx1=0, second=5, idx2=1.
- Enter 0,0,0,0,0 and start. Required: largest=0, idx1=0, second=0, idx2=1.
- Enter 15,1,15,15,2 and start. Required: idx1=0, idx2=2.
- With 4 slots filled, pulse st. Required: ignored, busy stays 0.
- Enter a 5th and a 6th value. Required: 6th ignored, buf[4] unchanged, count=5.
- Pulse st and enter together on a full buffer. Required: scan starts and enter is ignored.
- Start a scan, then pulse clear on the 2nd SCAN cycle. Required: no load, count=0, previous results held.
- Assert rst_n=0 mid-scan. Required: all outputs 0 immediately, with no clock edge needed.
- After one completed sort, pulse st again with no new entries. Required: identical results, load pulses again.
